imem_loader: RTL



---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: writes a byte-addressed instruction store from a 32-bit word
// stream (valid/ready), one byte per cycle MSB first, and serves big-endian
// 32-bit fetches on the same store while no load session is in progress.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [31:0]       ld_word,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              done,
    output logic [6:0]        word_count,
    input  logic [ADDR_W-1:0] A,
    output logic [31:0]       I
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WC_W   = 7;
    localparam int unsigned BIDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   ptr_q,    ptr_d;
    logic [BIDX_W-1:0]   bidx_q,   bidx_d;
    logic [WC_W-1:0]     wc_q,     wc_d;
    logic [WORD_W-1:0]   word_q,   word_d;
    logic                last_q,   last_d;
    logic                ready_q,  ready_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic                mem_we;
    logic [BYTE_W-1:0]   mem_wdata;

    // Instruction store; deliberately has no reset so a Clr keeps loaded code.
    logic [BYTE_W-1:0]   mem_q [DEPTH];

    // Fetch address of each byte of the big-endian word (wraps mod 2**ADDR_W).
    logic [ADDR_W-1:0]   a_0;
    logic [ADDR_W-1:0]   a_1;
    logic [ADDR_W-1:0]   a_2;
    logic [ADDR_W-1:0]   a_3;

    // Select the byte of the captured word that goes out on this WRITE cycle.
    always_comb begin
        mem_wdata = word_q[31:24];
        case (bidx_q)
            2'd0:    mem_wdata = word_q[31:24];
            2'd1:    mem_wdata = word_q[23:16];
            2'd2:    mem_wdata = word_q[15:8];
            2'd3:    mem_wdata = word_q[7:0];
            default: mem_wdata = word_q[31:24];
        endcase
    end

    // Session sequencing: next state, datapath updates and Moore outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bidx_d  = bidx_q;
        wc_d    = wc_q;
        word_d  = word_q;
        last_d  = last_q;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    ptr_d   = ld_base;
                    wc_d    = '0;
                    state_d = S_ACCEPT;
                end
            end

            S_ACCEPT: begin
                if (ld_valid) begin
                    word_d  = ld_word;
                    last_d  = ld_last;
                    wc_d    = wc_q + WC_W'(1);
                    bidx_d  = '0;
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + ADDR_W'(1);
                bidx_d = bidx_q + BIDX_W'(1);
                if (bidx_q == BIDX_W'(3)) begin
                    state_d = last_q ? S_DONE : S_ACCEPT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the decode of the next state,
        // so they track the state register cycle for cycle.
        ready_d = (state_d == S_ACCEPT);
        busy_d  = (state_d == S_ACCEPT) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    // Control and datapath registers with synchronous Clr.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            bidx_q  <= '0;
            wc_q    <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bidx_q  <= bidx_d;
            wc_q    <= wc_d;
            word_q  <= word_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Byte write port; Clr suppresses the write on the edge it is sampled.
    always_ff @(posedge Clk) begin
        if (!Clr && mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    // Fetch byte addresses, wrapping at the top of the store.
    always_comb begin
        a_0 = A;
        a_1 = A + ADDR_W'(1);
        a_2 = A + ADDR_W'(2);
        a_3 = A + ADDR_W'(3);
    end

    // Combinational big-endian fetch, forced to zero while a session runs.
    always_comb begin
        I = '0;
        if (!busy_q) begin
            I = {mem_q[a_0], mem_q[a_1], mem_q[a_2], mem_q[a_3]};
        end
    end

    assign ld_ready   = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = wc_q;

endmodule
